// File: rtl/demux_byte_scanner_if.sv
// Byte-in handshake plus serial bit/select outputs
// of the demux byte scanner.
interface demux_byte_scanner_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       a;
  logic [2:0] s;
  logic       out_valid;
  logic       busy;
  logic       done;

  modport master (
    output in_valid, in_data,
    input  in_ready, a, s, out_valid, busy, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, a, s, out_valid, busy, done
  );
endinterface

// File: rtl/demux_byte_scanner.sv
// Serialises one byte onto a/s for a 1-to-8 demux,
// holding each select value for HOLD_CYCLES cycles.
module demux_byte_scanner #(
  parameter int HOLD_CYCLES = 1,
  parameter bit LSB_FIRST   = 1'b1
) (
  input logic            clk,
  input logic            rst,
  demux_byte_scanner_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [2:0] IDX_FIRST = LSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [2:0] IDX_LAST  = LSB_FIRST ? 3'd7 : 3'd0;

  state_e     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] hold_q, hold_d;
  logic       rdy_q, rdy_d;
  logic       a_q, a_d;
  logic [2:0] s_q, s_d;
  logic       vld_q, vld_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [2:0] idx_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      byte_q  <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      rdy_q   <= 1'b1;
      a_q     <= 1'b0;
      s_q     <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      rdy_q   <= rdy_d;
      a_q     <= a_d;
      s_q     <= s_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    rdy_d   = rdy_q;
    a_d     = a_q;
    s_d     = s_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    idx_nxt = LSB_FIRST ? idx_q + 3'd1
                        : idx_q - 3'd1;
    unique case (state_q)
      IDLE: begin
        rdy_d  = 1'b1;
        a_d    = 1'b0;
        s_d    = '0;
        vld_d  = 1'b0;
        busy_d = 1'b0;
        if (bus.in_valid) begin
          state_d = SCAN;
          byte_d  = bus.in_data;
          idx_d   = IDX_FIRST;
          hold_d  = '0;
          rdy_d   = 1'b0;
          a_d     = bus.in_data[IDX_FIRST];
          s_d     = IDX_FIRST;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          // last index ends the scan; no wrap
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            rdy_d   = 1'b1;
            a_d     = 1'b0;
            s_d     = '0;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_nxt;
            s_d   = idx_nxt;
            a_d   = byte_q[idx_nxt];
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = rdy_q;
  assign bus.a         = a_q;
  assign bus.s         = s_q;
  assign bus.out_valid = vld_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_demux_byte_scanner.sv
// Random plus directed stimulus on three scanner
// configurations, checked against a timing model.
module tb_demux_byte_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_byte_scanner_if b0 ();
  demux_byte_scanner_if b1 ();
  demux_byte_scanner_if b2 ();

  demux_byte_scanner #(.HOLD_CYCLES(1), .LSB_FIRST(1'b1))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  demux_byte_scanner #(.HOLD_CYCLES(3), .LSB_FIRST(1'b1))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  demux_byte_scanner #(.HOLD_CYCLES(2), .LSB_FIRST(1'b0))
    u2 (.clk(clk), .rst(rst), .bus(b2));

  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         hold_p [3] = '{1, 3, 2};
  bit         lsb_p  [3] = '{1'b1, 1'b1, 1'b0};
  bit         act    [3];
  int         acc    [3];
  logic [7:0] byt    [3];

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b",
               tag, cyc, got, exp);
    end
  endtask

  // {in_ready, a, s[2:0], out_valid, busy, done}
  function automatic logic [7:0] model(input int i);
    int off, pos, idx;
    logic [2:0] s3;
    off = cyc - acc[i] - 1;
    if (act[i] && off < 8 * hold_p[i]) begin
      pos = off / hold_p[i];
      idx = lsb_p[i] ? pos : 7 - pos;
      s3  = 3'(idx);
      return {1'b0, byt[i][idx], s3, 3'b110};
    end
    if (act[i] && off == 8 * hold_p[i])
      return 8'b1000_0001;
    return 8'b1000_0000;
  endfunction

  function automatic logic [7:0] pack(input int i);
    case (i)
      0: return {b0.in_ready, b0.a, b0.s,
                 b0.out_valid, b0.busy, b0.done};
      1: return {b1.in_ready, b1.a, b1.s,
                 b1.out_valid, b1.busy, b1.done};
      default:
         return {b2.in_ready, b2.a, b2.s,
                 b2.out_valid, b2.busy, b2.done};
    endcase
  endfunction

  task automatic step(input logic r,
                      input logic v,
                      input logic [7:0] d);
    logic rdy [3];
    rst = r;
    b0.in_valid = v; b0.in_data = d;
    b1.in_valid = v; b1.in_data = d;
    b2.in_valid = v; b2.in_data = d;
    for (int i = 0; i < 3; i++)
      rdy[i] = model(i)[7];
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) act[i] = 1'b0;
      else if (rdy[i] && v) begin
        act[i] = 1'b1;
        acc[i] = cyc;
        byt[i] = d;
      end
    end
    cyc++;
    @(negedge clk);
    chk("cfg0", pack(0), model(0));
    chk("cfg1", pack(1), model(1));
    chk("cfg2", pack(2), model(2));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b0; acc[i] = 0; byt[i] = '0;
    end
    b0.in_valid = 1'b0; b0.in_data = '0;
    b1.in_valid = 1'b0; b1.in_data = '0;
    b2.in_valid = 1'b0; b2.in_data = '0;
    @(negedge clk);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hA5);
    repeat (30) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    repeat (40) step(1'b0, 1'b1, 8'h00);
    repeat (30) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    repeat (30) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h80);
    for (int k = 0; k < 30; k++)
      step(1'b0, 1'b0, k[0] ? 8'hFF : 8'h00);
    step(1'b0, 1'b1, 8'h3C);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hC3);
    step(1'b0, 1'b1, 8'h96);
    repeat (30) step(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 4000; k++)
      step($urandom_range(0, 199) == 0,
           1'($urandom),
           8'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
